// File: rtl/timer_apb_ctrl_if.sv
// APB bus bundle for the timer controller: requester drives select/address/data,
// the timer returns ready, read data and error.
interface timer_apb_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/timer_apb_ctrl.sv
// APB register front-end of a 64-bit timer: control/compare registers, coherent
// counter read-back, compare-match interrupt and debug halt request.
module timer_apb_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    timer_apb_ctrl_if.slave        apb,
    input  logic                   dbg_mode,
    input  logic [63:0]            counter,
    output logic [3:0]             div_val,
    output logic                   div_en,
    output logic                   timer_en,
    output logic                   halt_req,
    output logic [31:0]            wr_data,
    output logic                   tdr0_wr_en,
    output logic                   tdr1_wr_en,
    output logic                   tim_int
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [9:0] A_TCR   = 10'd0;
    localparam logic [9:0] A_TDR0  = 10'd1;
    localparam logic [9:0] A_TDR1  = 10'd2;
    localparam logic [9:0] A_TCMP0 = 10'd3;
    localparam logic [9:0] A_TCMP1 = 10'd4;
    localparam logic [9:0] A_TIER  = 10'd5;
    localparam logic [9:0] A_TISR  = 10'd6;
    localparam logic [9:0] A_THCSR = 10'd7;

    logic [1:0]  state_q, state_d;
    logic        timer_en_q, timer_en_d, div_en_q, div_en_d;
    logic [3:0]  div_val_q, div_val_d;
    logic [31:0] tcmp0_q, tcmp0_d, tcmp1_q, tcmp1_d;
    logic        int_en_q, int_en_d, int_st_q, int_st_d, halt_en_q, halt_en_d;
    logic [31:0] shadow_q, shadow_d;
    logic        match_q, match_d;
    logic        pready_q, pready_d, pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d, wr_data_q, wr_data_d;
    logic        tdr0_q, tdr0_d, tdr1_q, tdr1_d;

    logic [9:0]  addr_s;
    logic        mapped_s, tcr_bad_s, err_s, commit_s, match_rise_s, halt_req_s;
    logic [31:0] rdata_s;
    logic        unused_paddr_s;

    assign addr_s         = apb.paddr[11:2];
    assign unused_paddr_s = ^apb.paddr[1:0];
    assign mapped_s       = (addr_s <= A_THCSR);
    assign halt_req_s     = halt_en_q & dbg_mode;
    // While running, only the enable bit may be toggled; divider fields are frozen.
    assign tcr_bad_s      = timer_en_q & ((apb.pwdata[1] != div_en_q) || (apb.pwdata[11:8] != div_val_q));
    assign err_s          = ~mapped_s | (apb.pwrite & (addr_s == A_TCR) & tcr_bad_s);
    assign commit_s       = (state_q == S_ACCESS) & apb.psel & apb.pwrite & ~pslverr_q;
    assign match_d        = timer_en_q & (counter == {tcmp1_q, tcmp0_q});
    assign match_rise_s   = match_d & ~match_q;

    // APB phase sequencing
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = (apb.psel & ~apb.penable) ? S_SETUP : S_IDLE;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: state_d = (apb.psel & ~apb.penable) ? S_SETUP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Read data multiplexer
    always_comb begin
        rdata_s = 32'd0;
        case (addr_s)
            A_TCR:   rdata_s = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
            A_TDR0:  rdata_s = counter[31:0];
            A_TDR1:  rdata_s = shadow_q;
            A_TCMP0: rdata_s = tcmp0_q;
            A_TCMP1: rdata_s = tcmp1_q;
            A_TIER:  rdata_s = {31'd0, int_en_q};
            A_TISR:  rdata_s = {31'd0, int_st_q};
            A_THCSR: rdata_s = {30'd0, halt_req_s, halt_en_q};
            default: rdata_s = 32'd0;
        endcase
    end

    // Response, counter-load strobe and shadow capture, launched so they are live in ACCESS
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = 32'd0;
        tdr0_d    = 1'b0;
        tdr1_d    = 1'b0;
        wr_data_d = wr_data_q;
        shadow_d  = shadow_q;
        if (state_q == S_SETUP) begin
            pready_d  = 1'b1;
            pslverr_d = err_s;
            if (apb.pwrite) begin
                tdr0_d = (addr_s == A_TDR0);
                tdr1_d = (addr_s == A_TDR1);
                if ((addr_s == A_TDR0) || (addr_s == A_TDR1)) begin
                    wr_data_d = apb.pwdata;
                end else begin
                    wr_data_d = wr_data_q;
                end
            end else begin
                prdata_d = err_s ? 32'd0 : rdata_s;
                if (addr_s == A_TDR0) begin
                    shadow_d = counter[63:32];
                end else begin
                    shadow_d = shadow_q;
                end
            end
        end else begin
            pready_d = 1'b0;
        end
    end

    // Register write commit at the end of ACCESS; a set from a match outranks W1C
    always_comb begin
        timer_en_d = timer_en_q;
        div_en_d   = div_en_q;
        div_val_d  = div_val_q;
        tcmp0_d    = tcmp0_q;
        tcmp1_d    = tcmp1_q;
        int_en_d   = int_en_q;
        halt_en_d  = halt_en_q;
        if (commit_s) begin
            case (addr_s)
                A_TCR: begin
                    timer_en_d = apb.pwdata[0];
                    div_en_d   = apb.pwdata[1];
                    div_val_d  = apb.pwdata[11:8];
                end
                A_TCMP0: tcmp0_d   = apb.pwdata;
                A_TCMP1: tcmp1_d   = apb.pwdata;
                A_TIER:  int_en_d  = apb.pwdata[0];
                A_THCSR: halt_en_d = apb.pwdata[0];
                default: timer_en_d = timer_en_q;
            endcase
        end else begin
            timer_en_d = timer_en_q;
        end
        if (match_rise_s) begin
            int_st_d = 1'b1;
        end else if (commit_s && (addr_s == A_TISR) && apb.pwdata[0]) begin
            int_st_d = 1'b0;
        end else begin
            int_st_d = int_st_q;
        end
    end

    // State and register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= 4'd0;
            tcmp0_q    <= 32'hFFFF_FFFF;
            tcmp1_q    <= 32'hFFFF_FFFF;
            int_en_q   <= 1'b0;
            int_st_q   <= 1'b0;
            halt_en_q  <= 1'b0;
            shadow_q   <= 32'd0;
            match_q    <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= 32'd0;
            wr_data_q  <= 32'd0;
            tdr0_q     <= 1'b0;
            tdr1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_en_q <= timer_en_d;
            div_en_q   <= div_en_d;
            div_val_q  <= div_val_d;
            tcmp0_q    <= tcmp0_d;
            tcmp1_q    <= tcmp1_d;
            int_en_q   <= int_en_d;
            int_st_q   <= int_st_d;
            halt_en_q  <= halt_en_d;
            shadow_q   <= shadow_d;
            match_q    <= match_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_data_q  <= wr_data_d;
            tdr0_q     <= tdr0_d;
            tdr1_q     <= tdr1_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign timer_en    = timer_en_q;
    assign div_en      = div_en_q;
    assign div_val     = div_val_q;
    assign wr_data     = wr_data_q;
    assign tdr0_wr_en  = tdr0_q;
    assign tdr1_wr_en  = tdr1_q;
    assign halt_req    = halt_req_s;
    assign tim_int     = int_st_q & int_en_q;
endmodule
